// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file control port:
//   - register-file geometry (address width, data width, depth)
//   - controller state encoding
//   - latched debug command record
//   - core strobe priority helper (write > inc > dec)
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int RF_ADDR_W = 4;
    localparam int RF_DATA_W = 8;
    localparam int RF_DEPTH  = 16;

    // Controller states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DBG_WR = 2'd1;
    localparam logic [1:0] ST_DBG_RD = 2'd2;
    localparam logic [1:0] ST_CLEAR  = 2'd3;

    // Debug command captured at acceptance time
    typedef struct packed {
        logic                 we;
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] wdata;
    } dbg_cmd_t;

    // Reduce the core's write/inc/dec requests to at most one strobe.
    // Result bit order is {write, inc, dec}.
    function automatic logic [2:0] strobe_prio(input logic we,
                                               input logic inc,
                                               input logic dec);
        logic [2:0] stb;
        stb[2] = we;
        stb[1] = inc & ~we;
        stb[0] = dec & ~we & ~inc;
        return stb;
    endfunction

endpackage

// File: rtl/regfile_starve_cnt.sv
// -----------------------------------------------------------------------------
// regfile_starve_cnt
// Saturating counter tracking how many consecutive cycles a pending debug
// request has been blocked by the core.
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   i_inc       count one more blocked cycle
//   i_clr       clear the count (request granted); wins over i_inc
//   o_at_limit  count has reached LIMIT
// -----------------------------------------------------------------------------
module regfile_starve_cnt #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);

    localparam int CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_at_limit = (r_cnt == CNT_W'(LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_at_limit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_port_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_port_ctrl
// Arbitrates the 16 x 8-bit register file control port between the core
// datapath, a debug requester (req/ack) and a clear sequencer.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   core_*                    core select/data/strobes in, core_stall out
//   dbg_req/we/addr/wdata     debug request (held until dbg_ack)
//   dbg_ack, dbg_rdata        one-cycle completion pulse, read result
//   clr_req, clr_busy         clear-sequence start, in-progress flag
//   rf_*                      register file select/data/strobes, rf_outb in
// -----------------------------------------------------------------------------
module regfile_port_ctrl
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int NREGS        = RF_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 core_en,
    input  logic [RF_ADDR_W-1:0] core_in_sel,
    input  logic [RF_ADDR_W-1:0] core_outb_sel,
    input  logic [RF_DATA_W-1:0] core_data,
    input  logic                 core_we,
    input  logic                 core_inc,
    input  logic                 core_dec,
    output logic                 core_stall,
    input  logic                 dbg_req,
    input  logic                 dbg_we,
    input  logic [RF_ADDR_W-1:0] dbg_addr,
    input  logic [RF_DATA_W-1:0] dbg_wdata,
    output logic                 dbg_ack,
    output logic [RF_DATA_W-1:0] dbg_rdata,
    input  logic                 clr_req,
    output logic                 clr_busy,
    output logic [RF_ADDR_W-1:0] rf_in_sel,
    output logic [RF_ADDR_W-1:0] rf_outb_sel,
    output logic [RF_DATA_W-1:0] rf_in,
    output logic                 rf_write_en,
    output logic                 rf_inc,
    output logic                 rf_dec,
    input  logic [RF_DATA_W-1:0] rf_outb
);

    localparam logic [RF_ADDR_W-1:0] LAST_IDX = RF_ADDR_W'(NREGS - 1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [RF_ADDR_W-1:0] r_clr_idx;
    logic [RF_ADDR_W-1:0] w_clr_idx_next;
    dbg_cmd_t             r_dbg_cmd;
    dbg_cmd_t             w_dbg_cmd_next;
    logic                 r_dbg_ack;
    logic [RF_DATA_W-1:0] r_dbg_rdata;

    logic                 w_idle;
    logic                 w_dbg_live;
    logic                 w_at_limit;
    logic                 w_force;
    logic                 w_grant;
    logic                 w_starve_inc;
    logic [2:0]           w_core_stb;

    assign w_idle = (r_state == ST_IDLE);

    // A request seen while its own ack is still out is the same request
    // being released; treating it as new would accept it twice.
    assign w_dbg_live = dbg_req && !r_dbg_ack;

    // clr_req outranks the debug grant, so neither a normal nor a forced
    // grant can happen in a cycle that starts a clear.
    assign w_force = w_idle && !clr_req && w_dbg_live && w_at_limit;
    assign w_grant = w_idle && !clr_req && w_dbg_live && (!core_en || w_at_limit);

    assign w_starve_inc = w_idle && w_dbg_live && core_en && !w_grant;

    regfile_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .i_inc      (w_starve_inc),
        .i_clr      (w_grant),
        .o_at_limit (w_at_limit)
    );

    assign w_core_stb = strobe_prio(core_we, core_inc, core_dec)
                      & {3{core_en && !w_force}};

    // Register-file drive
    always_comb begin
        rf_in_sel   = core_in_sel;
        rf_outb_sel = core_outb_sel;
        rf_in       = core_data;
        rf_write_en = 1'b0;
        rf_inc      = 1'b0;
        rf_dec      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                rf_write_en = w_core_stb[2];
                rf_inc      = w_core_stb[1];
                rf_dec      = w_core_stb[0];
            end
            ST_DBG_WR: begin
                rf_in_sel   = r_dbg_cmd.addr;
                rf_in       = r_dbg_cmd.wdata;
                rf_write_en = 1'b1;
            end
            ST_DBG_RD: begin
                rf_outb_sel = r_dbg_cmd.addr;
            end
            ST_CLEAR: begin
                rf_in_sel   = r_clr_idx;
                rf_in       = '0;
                rf_write_en = 1'b1;
            end
            default: ;
        endcase
    end

    assign core_stall = core_en && (!w_idle || w_force);
    assign clr_busy   = (r_state == ST_CLEAR);
    assign dbg_ack    = r_dbg_ack;
    assign dbg_rdata  = r_dbg_rdata;

    // Next-state logic
    always_comb begin
        w_state_next   = r_state;
        w_clr_idx_next = r_clr_idx;
        w_dbg_cmd_next = r_dbg_cmd;
        case (r_state)
            ST_IDLE: begin
                if (clr_req) begin
                    w_state_next = ST_CLEAR;
                end else if (w_grant) begin
                    w_dbg_cmd_next.we    = dbg_we;
                    w_dbg_cmd_next.addr  = dbg_addr;
                    w_dbg_cmd_next.wdata = dbg_wdata;
                    w_state_next         = dbg_we ? ST_DBG_WR : ST_DBG_RD;
                end
            end
            ST_DBG_WR, ST_DBG_RD: begin
                w_state_next = ST_IDLE;
            end
            ST_CLEAR: begin
                if (r_clr_idx == LAST_IDX) begin
                    w_clr_idx_next = '0;
                    w_state_next   = ST_IDLE;
                end else begin
                    w_clr_idx_next = r_clr_idx + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_clr_idx   <= '0;
            r_dbg_cmd   <= '0;
            r_dbg_ack   <= 1'b0;
            r_dbg_rdata <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_idx <= w_clr_idx_next;
            r_dbg_cmd <= w_dbg_cmd_next;
            // Ack follows the single operation cycle of either debug state
            r_dbg_ack <= (r_state == ST_DBG_WR) || (r_state == ST_DBG_RD);
            if (r_state == ST_DBG_RD) begin
                r_dbg_rdata <= rf_outb;
            end
        end
    end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regfile_port_ctrl
// Directed stimulus pushes expected register-file strobe events and debug
// acks (with the cycle they must appear in) into a queue; a monitor pops and
// compares whenever the DUT drives a strobe or an ack.
// -----------------------------------------------------------------------------
module tb_regfile_port_ctrl;

    localparam logic [1:0] K_WR  = 2'd0;
    localparam logic [1:0] K_INC = 2'd1;
    localparam logic [1:0] K_DEC = 2'd2;
    localparam logic [1:0] K_ACK = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [3:0]  sel;
        logic [7:0]  data;
        logic        stall;
        logic [31:0] cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       core_en;
    logic [3:0] core_in_sel;
    logic [3:0] core_outb_sel;
    logic [7:0] core_data;
    logic       core_we;
    logic       core_inc;
    logic       core_dec;
    logic       core_stall;
    logic       dbg_req;
    logic       dbg_we;
    logic [3:0] dbg_addr;
    logic [7:0] dbg_wdata;
    logic       dbg_ack;
    logic [7:0] dbg_rdata;
    logic       clr_req;
    logic       clr_busy;
    logic [3:0] rf_in_sel;
    logic [3:0] rf_outb_sel;
    logic [7:0] rf_in;
    logic       rf_write_en;
    logic       rf_inc;
    logic       rf_dec;
    logic [7:0] rf_outb;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    logic       mon_on  = 1'b0;
    ev_t        exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Simple register-file model: only writes matter for this bench
    logic [7:0] rf_mem [16] = '{default: 8'h00};
    always @(posedge clk) if (rf_write_en) rf_mem[rf_in_sel] <= rf_in;
    assign rf_outb = rf_mem[rf_outb_sel];

    regfile_port_ctrl #(
        .STARVE_LIMIT (8),
        .NREGS        (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .core_en       (core_en),
        .core_in_sel   (core_in_sel),
        .core_outb_sel (core_outb_sel),
        .core_data     (core_data),
        .core_we       (core_we),
        .core_inc      (core_inc),
        .core_dec      (core_dec),
        .core_stall    (core_stall),
        .dbg_req       (dbg_req),
        .dbg_we        (dbg_we),
        .dbg_addr      (dbg_addr),
        .dbg_wdata     (dbg_wdata),
        .dbg_ack       (dbg_ack),
        .dbg_rdata     (dbg_rdata),
        .clr_req       (clr_req),
        .clr_busy      (clr_busy),
        .rf_in_sel     (rf_in_sel),
        .rf_outb_sel   (rf_outb_sel),
        .rf_in         (rf_in),
        .rf_write_en   (rf_write_en),
        .rf_inc        (rf_inc),
        .rf_dec        (rf_dec),
        .rf_outb       (rf_outb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic [1:0] kind, input logic [3:0] sel,
                             input logic [7:0] data, input logic stall,
                             input int at_cyc);
        ev_t e;
        e.kind  = kind;
        e.sel   = sel;
        e.data  = data;
        e.stall = stall;
        e.cyc   = 32'(at_cyc);
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end else begin
            $display("[TB] ok   %s = %0h (cycle %0d)", name, got, cyc);
        end
    endtask

    task automatic score(input ev_t got);
        ev_t want;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got kind=%0d sel=%0d data=%02h stall=%0d cyc=%0d, expected no event",
                     got.kind, got.sel, got.data, got.stall, got.cyc);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                n_fail++;
                $display("FAIL sb_event: got kind=%0d sel=%0d data=%02h stall=%0d cyc=%0d, expected kind=%0d sel=%0d data=%02h stall=%0d cyc=%0d",
                         got.kind, got.sel, got.data, got.stall, got.cyc,
                         want.kind, want.sel, want.data, want.stall, want.cyc);
            end else begin
                $display("[TB] ok   event kind=%0d sel=%0d data=%02h stall=%0d cyc=%0d",
                         got.kind, got.sel, got.data, got.stall, got.cyc);
            end
        end
    endtask

    // Monitor: strobe events first, then ack, in the same cycle
    always @(negedge clk) begin
        ev_t got;
        if (mon_on) begin
            if (rf_write_en || rf_inc || rf_dec) begin
                n_tests++;
                if ((int'(rf_write_en) + int'(rf_inc) + int'(rf_dec)) > 1) begin
                    n_fail++;
                    $display("FAIL strobe_excl: got we=%0d inc=%0d dec=%0d, expected one-hot (cycle %0d)",
                             rf_write_en, rf_inc, rf_dec, cyc);
                end
                got.kind  = rf_write_en ? K_WR : (rf_inc ? K_INC : K_DEC);
                got.sel   = rf_in_sel;
                got.data  = rf_write_en ? rf_in : 8'h00;
                got.stall = core_stall;
                got.cyc   = 32'(cyc);
                score(got);
            end
            if (dbg_ack) begin
                got.kind  = K_ACK;
                got.sel   = 4'h0;
                got.data  = dbg_rdata;
                got.stall = core_stall;
                got.cyc   = 32'(cyc);
                score(got);
            end
        end
    end

    initial begin
        int t;
        int stall_cnt;
        int busy_cnt;

        rst = 1'b1;
        core_en = 0; core_in_sel = 0; core_outb_sel = 0; core_data = 0;
        core_we = 0; core_inc = 0; core_dec = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; clr_req = 0;
        tick();
        tick();
        rst = 1'b0;
        mon_on = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_dbg_ack",    32'(dbg_ack),     32'd0);
        check("rst_dbg_rdata",  32'(dbg_rdata),   32'd0);
        check("rst_clr_busy",   32'(clr_busy),    32'd0);
        check("rst_core_stall", 32'(core_stall),  32'd0);
        check("rst_write_en",   32'(rf_write_en), 32'd0);
        tick();

        // 1. Core write passes through in the same cycle
        core_en = 1; core_we = 1; core_in_sel = 4'd3; core_data = 8'hA5;
        expect_ev(K_WR, 4'd3, 8'hA5, 1'b0, cyc);
        tick();
        core_en = 0; core_we = 0;

        // 2. Debug write with core idle: op at T+1, ack at T+2
        dbg_req = 1; dbg_we = 1; dbg_addr = 4'd7; dbg_wdata = 8'h3C;
        expect_ev(K_WR,  4'd7, 8'h3C, 1'b0, cyc + 1);
        expect_ev(K_ACK, 4'd0, 8'h00, 1'b0, cyc + 2);
        tick();
        tick();
        dbg_req = 0;
        tick();

        // Strobe priority we > inc > dec
        core_en = 1; core_we = 1; core_inc = 1; core_dec = 1;
        core_in_sel = 4'd1; core_data = 8'h99;
        expect_ev(K_WR, 4'd1, 8'h99, 1'b0, cyc);
        tick();
        core_we = 0; core_in_sel = 4'd6;
        expect_ev(K_INC, 4'd6, 8'h00, 1'b0, cyc);
        tick();
        core_inc = 0; core_in_sel = 4'd8;
        expect_ev(K_DEC, 4'd8, 8'h00, 1'b0, cyc);
        tick();
        core_en = 0; core_dec = 0;

        // 3. Debug read of register 5 holding 0x42
        core_en = 1; core_we = 1; core_in_sel = 4'd5; core_data = 8'h42;
        expect_ev(K_WR, 4'd5, 8'h42, 1'b0, cyc);
        tick();
        core_en = 0; core_we = 0;
        dbg_req = 1; dbg_we = 0; dbg_addr = 4'd5;
        expect_ev(K_ACK, 4'd0, 8'h42, 1'b0, cyc + 2);
        tick();
        @(negedge clk);
        check("rd_outb_sel", 32'(rf_outb_sel), 32'd5);
        tick();
        dbg_req = 0;
        tick();

        // 4. Starvation: 8 blocked cycles, forced grant, then debug write
        t = cyc;
        core_en = 1; core_we = 1; core_in_sel = 4'd2; core_data = 8'h11;
        dbg_req = 1; dbg_we = 1; dbg_addr = 4'd9; dbg_wdata = 8'h77;
        for (int i = 0; i < 8; i++) expect_ev(K_WR, 4'd2, 8'h11, 1'b0, t + i);
        expect_ev(K_WR,  4'd9, 8'h77, 1'b1, t + 9);
        expect_ev(K_WR,  4'd2, 8'h11, 1'b0, t + 10);
        expect_ev(K_ACK, 4'd0, 8'h42, 1'b0, t + 10);
        stall_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            stall_cnt += int'(core_stall);
            tick();
        end
        dbg_req = 0; core_en = 0; core_we = 0;
        check("starve_stall_cycles", 32'(stall_cnt), 32'd2);
        tick();

        // 5. Clear with core active: 16 zero writes, core stalled throughout
        t = cyc;
        core_en = 1; core_we = 1; core_in_sel = 4'd4; core_data = 8'h55;
        clr_req = 1;
        expect_ev(K_WR, 4'd4, 8'h55, 1'b0, t);
        for (int i = 0; i < 16; i++) expect_ev(K_WR, 4'(i), 8'h00, 1'b1, t + 1 + i);
        expect_ev(K_WR, 4'd4, 8'h55, 1'b0, t + 17);
        tick();
        clr_req = 0;
        busy_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            busy_cnt += int'(clr_busy);
            tick();
        end
        @(negedge clk);
        check("clr_busy_after", 32'(clr_busy), 32'd0);
        tick();
        core_en = 0; core_we = 0;
        check("clr_busy_cycles", 32'(busy_cnt), 32'd16);
        tick();

        // 6. Reset while the clear is at index 6
        t = cyc;
        clr_req = 1;
        for (int i = 0; i < 7; i++) expect_ev(K_WR, 4'(i), 8'h00, 1'b0, t + 1 + i);
        tick();
        clr_req = 0;
        while (cyc < t + 7) tick();
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        check("post_rst_write_en", 32'(rf_write_en), 32'd0);
        check("post_rst_clr_busy", 32'(clr_busy),    32'd0);
        check("post_rst_dbg_ack",  32'(dbg_ack),     32'd0);
        check("post_rst_rdata",    32'(dbg_rdata),   32'd0);
        repeat (4) tick();

        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_port_ctrl.md
Name: regfile_port_ctrl

Overview:
Owns the control port of the 16 x 8-bit CPU register file and shares it between three sources:
- the core datapath (write, 16-bit pair inc/dec, operand select);
- a debug requester (single-register read or write, req/ack handshake);
- a clear sequencer that zeroes all 16 registers.

It sits between the core control unit / debug bridge and the register file. It drives the register file's select, data and enable inputs, and returns stall/ack status to the requesters.

Parameters:
- STARVE_LIMIT, 8: consecutive cycles a pending debug request may be blocked by the core before the core is forcibly stalled.
- NREGS, 16: registers cleared by the clear sequence. Fixed to the register-file depth.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- core_en  in  1  core wants the port this cycle
- core_in_sel  in  4  core write/inc-dec select
- core_outb_sel  in  4  core operand-B / pair select
- core_data  in  8  core write data
- core_we  in  1  core write strobe
- core_inc  in  1  core pair increment strobe
- core_dec  in  1  core pair decrement strobe
- core_stall  out  1  core request not serviced this cycle
- dbg_req  in  1  debug request; held until dbg_ack
- dbg_we  in  1  1 = write, 0 = read; sampled with dbg_req
- dbg_addr  in  4  debug register index
- dbg_wdata  in  8  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  8  read result; valid with dbg_ack, held until next read
- clr_req  in  1  start clear sequence (pulse or level)
- clr_busy  out  1  clear sequence in progress
- rf_in_sel  out  4  to register file inSelect
- rf_outb_sel  out  4  to register file outBselect
- rf_in  out  8  to register file in
- rf_write_en  out  1  to register file write_en
- rf_inc  out  1  to register file inc
- rf_dec  out  1  to register file dec
- rf_outb  in  8  from register file outB

Behaviour:
- Single clock, clk. rst is synchronous and active-high.
- Reset values: state IDLE; clear index 0; starve counter 0; dbg_ack 0; dbg_rdata 0; clr_busy 0; core_stall 0 (combinational). A reset mid-operation aborts it; no register-file strobe is issued in the cycle after reset.
- rf_* outputs are combinational from state, latched debug fields and core inputs.

States: IDLE, DBG_WR, DBG_RD, CLEAR.

IDLE:
- rf_in_sel = core_in_sel; rf_outb_sel = core_outb_sel; rf_in = core_data.
- Strobes = core_we / core_inc / core_dec, each gated by core_en and by forced-grant not firing. Pass-through is zero latency.
- Next-state priority:
  1. clr_req → CLEAR. The core is still serviced this cycle.
  2. dbg_req && (!core_en || starve == STARVE_LIMIT) && !dbg_ack → latch dbg_we/addr/wdata, go to DBG_WR or DBG_RD, clear starve.
  3. Otherwise stay in IDLE.
- starve increments while dbg_req && core_en && not granted; it saturates at STARVE_LIMIT.
- Forced grant (starve == STARVE_LIMIT): core strobes are suppressed and core_stall = core_en in that IDLE cycle.
- dbg_req is ignored in a cycle where dbg_ack = 1. This prevents double acceptance.

DBG_WR (1 cycle):
- rf_in_sel = latched addr; rf_in = latched wdata; rf_write_en = 1; inc/dec = 0.
- Then go to IDLE. dbg_ack is a registered pulse in the next cycle.

DBG_RD (1 cycle):
- rf_outb_sel = latched addr; all strobes 0.
- At the clock edge, dbg_rdata <= rf_outb. Then go to IDLE; dbg_ack pulses in the next cycle.

Debug latency: request accepted at T, operation at T+1, dbg_ack at T+2.

CLEAR (NREGS cycles):
- clr_busy = 1.
- rf_in_sel = index; rf_in = 0; rf_write_en = 1; inc/dec = 0.
- index increments each cycle; after index 15, go to IDLE with index reset to 0.
- clr_req is ignored while busy. Pending dbg_req waits and is serviced afterwards.

Common rules:
- core_stall = core_en whenever state != IDLE, and during a forced grant. The core must hold its request while stalled.
- Strobe exclusivity: at most one of rf_write_en, rf_inc, rf_dec is driven. If the core asserts several, priority is we > inc > dec.

Decomposition:
- Shared package regfile_pkg holds:
  - the state encoding (IDLE=0, DBG_WR=1, DBG_RD=2, CLEAR=3);
  - RF_ADDR_W=4, RF_DATA_W=8, RF_DEPTH=16.
- One sub-module is natural: regfile_starve_cnt, the saturating counter with a limit-reached flag.

Test Plan:
1. Core-only: core_en=1, core_we=1, core_in_sel=3, core_data=0xA5 → same cycle rf_write_en=1, rf_in_sel=3, rf_in=0xA5, core_stall=0.
2. Debug write while core idle: dbg_req, dbg_we=1, addr=7, wdata=0x3C at T → rf_write_en=1, rf_in_sel=7, rf_in=0x3C at T+1; dbg_ack=1 at T+2 only.
3. Debug read: register 5 holds 0x42; dbg_req, dbg_we=0, addr=5 → rf_outb_sel=5 at T+1; dbg_ack=1 and dbg_rdata=0x42 at T+2.
4. Starvation: core_en=1 continuously with dbg_req held → grant after 8 blocked cycles; core_stall=1 for exactly 2 cycles (the forced-grant IDLE cycle and the DBG cycle); dbg_ack follows.
5. Clear: clr_req pulse with core_en=1 → 16 consecutive writes of 0 to indices 0..15; clr_busy=1 and core_stall=1 throughout; back to IDLE on cycle 17.
6. Reset mid-CLEAR at index 6 → the next cycle has no rf_write_en; state IDLE, clr_busy=0, dbg_ack=0, dbg_rdata=0.
